// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: op encodings, flag layout and
// the control-state enum. Decode imports the ALU_OP_* constants from here.
package alu_pkg;

    // Op encodings; 0..3 match the previous combinational ALU.
    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_LSL = 4'd1;
    localparam logic [3:0] ALU_OP_AND = 4'd2;
    localparam logic [3:0] ALU_OP_NOT = 4'd3;
    localparam logic [3:0] ALU_OP_SUB = 4'd4;
    localparam logic [3:0] ALU_OP_OR  = 4'd5;
    localparam logic [3:0] ALU_OP_XOR = 4'd6;
    localparam logic [3:0] ALU_OP_LSR = 4'd7;
    localparam logic [3:0] ALU_OP_ASR = 4'd8;
    localparam logic [3:0] ALU_OP_MUL = 4'd9;

    typedef enum logic [3:0] {
        OP_ADD = ALU_OP_ADD,
        OP_LSL = ALU_OP_LSL,
        OP_AND = ALU_OP_AND,
        OP_NOT = ALU_OP_NOT,
        OP_SUB = ALU_OP_SUB,
        OP_OR  = ALU_OP_OR,
        OP_XOR = ALU_OP_XOR,
        OP_LSR = ALU_OP_LSR,
        OP_ASR = ALU_OP_ASR,
        OP_MUL = ALU_OP_MUL
    } alu_op_e;

    // Packed so that the 4-bit flags port reads {N,Z,C,V}, MSB first.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle,
// LSB first. Operands are captured on start. The last of the WIDTH
// partial-product additions is folded into the combinational outputs, so
// done/product are valid in the cycle that the parent registers them,
// WIDTH edges after the start edge.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic             hi_nonzero
);

    localparam int CNT_W = $clog2(WIDTH);

    logic                 busy;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc_next;

    assign acc_next   = mplier[0] ? (acc + mcand) : acc;
    assign done       = busy && (count == CNT_W'(WIDTH - 1));
    assign product_lo = acc_next[WIDTH-1:0];
    assign hi_nonzero = |acc_next[2*WIDTH-1:WIDTH];

    // Load operands on start, then add one shifted partial product per cycle.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_pipe_hs.sv
// Handshaked ALU between decode and writeback. Single-cycle ops produce a
// registered result one edge after accept; MUL (when enabled) runs through
// the iterative multiplier. A DONE result can be consumed and a new op
// accepted on the same edge, giving one op per cycle.
module alu_pipe_hs
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    alu_state_e       state, state_next;
    alu_op_e          op_e;
    logic             accept;
    logic             is_mul;

    logic [WIDTH-1:0] alu_res;
    alu_flags_t       alu_fl;
    alu_flags_t       flags_q;

    logic [WIDTH:0]        sum_ext;
    logic [WIDTH:0]        diff_ext;
    logic [WIDTH:0]        shl_ext;
    logic [WIDTH:0]        shr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic                  amt_zero;
    logic                  amt_big;

    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    assign op_e   = alu_op_e'(op);
    assign is_mul = (MUL_EN != 0) && (op == ALU_OP_MUL);

    // Held low during reset so nothing is accepted before the FSM is live.
    assign in_ready  = rst_n && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign flags     = flags_q;

    // Extended forms: the extra bit carries the carry/borrow or the last
    // bit shifted out.
    assign sum_ext  = {1'b0, rs_val} + {1'b0, rt_val};
    assign diff_ext = {1'b0, rs_val} - {1'b0, rt_val};
    assign shl_ext  = {1'b0, rs_val} << rt_val;
    assign shr_ext  = {rs_val, 1'b0} >> rt_val;
    assign asr_ext  = $signed({rs_val, 1'b0}) >>> rt_val;
    assign amt_zero = (rt_val == '0);
    assign amt_big  = (rt_val >= WIDTH'(WIDTH));

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk        (clk),
                .rst_n      (rst_n),
                .start      (accept && is_mul),
                .a          (rs_val),
                .b          (rt_val),
                .done       (mul_done),
                .product_lo (mul_lo),
                .hi_nonzero (mul_hi_nz)
            );
        end else begin : g_no_mul
            assign mul_done  = 1'b0;
            assign mul_lo    = '0;
            assign mul_hi_nz = 1'b0;
        end
    endgenerate

    // Single-cycle datapath: result and flags for the op on the inputs.
    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        alu_res = '0;
        alu_fl  = '0;
        case (op_e)
            OP_ADD: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_fl.c = sum_ext[WIDTH];
                alu_fl.v = (rs_val[WIDTH-1] == rt_val[WIDTH-1]) &&
                           (alu_res[WIDTH-1] != rs_val[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = diff_ext[WIDTH-1:0];
                alu_fl.c = ~diff_ext[WIDTH];
                alu_fl.v = (rs_val[WIDTH-1] != rt_val[WIDTH-1]) &&
                           (alu_res[WIDTH-1] != rs_val[WIDTH-1]);
            end
            OP_AND: alu_res = rs_val & rt_val;
            OP_OR:  alu_res = rs_val | rt_val;
            OP_XOR: alu_res = rs_val ^ rt_val;
            OP_NOT: alu_res = ~rs_val;
            OP_LSL: begin
                if (!amt_big) begin
                    alu_res  = shl_ext[WIDTH-1:0];
                    alu_fl.c = shl_ext[WIDTH] && !amt_zero;
                end
            end
            OP_LSR: begin
                if (!amt_big) begin
                    alu_res  = shr_ext[WIDTH:1];
                    alu_fl.c = shr_ext[0] && !amt_zero;
                end
            end
            OP_ASR: begin
                if (amt_big) begin
                    alu_res  = {WIDTH{rs_val[WIDTH-1]}};
                    alu_fl.c = rs_val[WIDTH-1];
                end else begin
                    alu_res  = asr_ext[WIDTH:1];
                    alu_fl.c = asr_ext[0] && !amt_zero;
                end
            end
            default: alu_res = '0;
        endcase
        alu_fl.n = alu_res[WIDTH-1];
        alu_fl.z = (alu_res == '0);
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic for the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output bank: loaded by a single-cycle accept or by multiplier completion,
    // otherwise held, which keeps result/flags stable through a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            flags_q <= '0;
        end else if (accept && !is_mul) begin
            result  <= alu_res;
            flags_q <= alu_fl;
        end else if ((state == ST_BUSY) && mul_done) begin
            result  <= mul_lo;
            flags_q <= '{n: mul_lo[WIDTH-1], z: (mul_lo == '0), c: mul_hi_nz, v: 1'b0};
        end
    end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs (WIDTH=16, MUL_EN=1): a table of
// single-cycle vectors plus hand sequences for back-to-back issue, MUL
// latency, output stall and reset during a multiply.
module tb_alu_pipe_hs;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    alu_pipe_hs #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op (out_ready=1), check the registered output one edge later,
    // then let it be consumed. Called just after a rising edge.
    task automatic run_vec(input string name, input logic [3:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] res, input logic [3:0] fl);
        in_valid  = 1'b1;
        op        = o;
        rs_val    = a;
        rt_val    = b;
        out_ready = 1'b1;
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({name, ".out_valid"}, 32'(out_valid), 32'd1);
        check({name, ".result"}, 32'(result), 32'(res));
        check({name, ".flags"}, 32'(flags), 32'(fl));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hits;

        vecs[0]  = '{ALU_OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
        vecs[1]  = '{ALU_OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
        vecs[2]  = '{ALU_OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b0110};
        vecs[3]  = '{ALU_OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000};
        vecs[4]  = '{ALU_OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
        vecs[5]  = '{ALU_OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
        vecs[6]  = '{ALU_OP_OR,  16'hF000, 16'h000F, 16'hF00F, 4'b1000};
        vecs[7]  = '{ALU_OP_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};
        vecs[8]  = '{ALU_OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b1000};
        vecs[9]  = '{ALU_OP_LSL, 16'h8001, 16'd1,    16'h0002, 4'b0010};
        vecs[10] = '{ALU_OP_LSL, 16'h0001, 16'd16,   16'h0000, 4'b0100};
        vecs[11] = '{ALU_OP_LSL, 16'h0001, 16'd15,   16'h8000, 4'b1000};
        vecs[12] = '{ALU_OP_LSR, 16'h1234, 16'd0,    16'h1234, 4'b0000};
        vecs[13] = '{ALU_OP_LSR, 16'h0003, 16'd1,    16'h0001, 4'b0010};
        vecs[14] = '{ALU_OP_LSR, 16'hFFFF, 16'd16,   16'h0000, 4'b0100};
        vecs[15] = '{ALU_OP_ASR, 16'h8001, 16'd20,   16'hFFFF, 4'b1010};
        vecs[16] = '{ALU_OP_ASR, 16'h8000, 16'd4,    16'hF800, 4'b1000};
        vecs[17] = '{ALU_OP_ASR, 16'h7FFF, 16'd16,   16'h0000, 4'b0100};
        vecs[18] = '{4'd10,      16'h1234, 16'h5678, 16'h0000, 4'b0100};
        vecs[19] = '{4'd15,      16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        rs_val    = '0;
        rt_val    = '0;
        out_ready = 1'b1;

        // Reset state.
        #2;
        check("rst.in_ready",  32'(in_ready),  32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result",    32'(result),    32'd0);
        check("rst.flags",     32'(flags),     32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Table of single-cycle ops.
        for (int i = 0; i < NVEC; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].res, vecs[i].fl);
        end

        // ADD with out_ready=1 keeps in_ready high while the result is out.
        in_valid = 1'b1; op = ALU_OP_ADD; rs_val = 16'h7FFF; rt_val = 16'h0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("add.result",   32'(result),   32'h8000);
        check("add.flags",    32'(flags),    32'b1001);
        check("add.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back SUB then AND.
        in_valid = 1'b1; op = ALU_OP_SUB; rs_val = 16'd5; rt_val = 16'd5;
        @(posedge clk);
        #1;
        op = ALU_OP_AND; rs_val = 16'hF0F0; rt_val = 16'h0FF0;
        check("b2b.sub.valid",  32'(out_valid), 32'd1);
        check("b2b.sub.result", 32'(result),    32'h0000);
        check("b2b.sub.flags",  32'(flags),     32'b0110);
        check("b2b.in_ready",   32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b.and.valid",  32'(out_valid), 32'd1);
        check("b2b.and.result", 32'(result),    32'h00F0);
        check("b2b.and.flags",  32'(flags),     32'b0000);
        @(posedge clk);
        #1;
        check("b2b.drained", 32'(out_valid), 32'd0);

        // MUL latency with a stalled consumer; operands changed after accept.
        out_ready = 1'b0;
        in_valid = 1'b1; op = ALU_OP_MUL; rs_val = 16'h0100; rt_val = 16'h0101;
        @(posedge clk);
        #1;
        in_valid = 1'b0; rs_val = 16'hFFFF; rt_val = 16'hFFFF;
        for (int k = 0; k < W; k++) begin
            check($sformatf("mul.busy%0d", k), 32'({out_valid, in_ready}), 32'b00);
            @(posedge clk);
            #1;
        end
        check("mul.valid",  32'(out_valid), 32'd1);
        check("mul.result", 32'(result),    32'h0100);
        check("mul.flags",  32'(flags),     32'b0010);

        // Stall for 5 cycles with a new op waiting; it must not be taken.
        in_valid = 1'b1; op = ALU_OP_ADD; rs_val = 16'd1; rt_val = 16'd2;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d.valid", k),    32'(out_valid), 32'd1);
            check($sformatf("stall%0d.result", k),   32'(result),    32'h0100);
            check($sformatf("stall%0d.flags", k),    32'(flags),     32'b0010);
            check($sformatf("stall%0d.in_ready", k), 32'(in_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release.next_valid",  32'(out_valid), 32'd1);
        check("release.next_result", 32'(result),    32'h0003);
        check("release.next_flags",  32'(flags),     32'b0000);
        @(posedge clk);
        #1;
        check("release.drained", 32'(out_valid), 32'd0);

        // Reset in the middle of a MUL: op discarded, no output afterwards.
        in_valid = 1'b1; op = ALU_OP_MUL; rs_val = 16'h0003; rt_val = 16'h0005;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.out_valid", 32'(out_valid), 32'd0);
        check("mid_rst.in_ready",  32'(in_ready),  32'd0);
        check("mid_rst.result",    32'(result),    32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst.ready_after", 32'(in_ready), 32'd1);
        hits = 0;
        for (int k = 0; k < 2 * W; k++) begin
            if (out_valid) hits++;
            @(posedge clk);
            #1;
        end
        check("mid_rst.no_output", 32'(hits), 32'd0);
        run_vec("post_rst_add", ALU_OP_ADD, 16'd1, 16'd1, 16'd2, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
